// File: rtl/reg_bank_slave.sv
// reg_bank_slave: small register bank behind a valid/ready request port.
// A request is accepted from IDLE when valid and ready are both high.
// The slave then spends WAIT_CYC cycles in WAIT and one cycle in RESP.
// In the RESP cycle it raises rvalid together with rdata and err.
//
// Optional feature: `define REG_BANK_WSTRB_EN adds a byte-strobe input.
// When the macro is absent, every write updates all DW bits.
//
// Parameters
//   DW       register/data width (multiple of 8)
//   NREG     number of implemented registers (1..2**AW)
//   AW       address width
//   WAIT_CYC wait states between accept and response (0..15)
// Ports
//   clk      rising-edge clock
//   rst      synchronous active-high reset
//   valid    request present
//   we       1 = write, 0 = read
//   addr     register index
//   wdata    write data
//   wstrb    byte strobes (only with REG_BANK_WSTRB_EN)
//   ready    slave can accept a request (IDLE and not in reset)
//   rvalid   one-cycle response strobe
//   rdata    read data, zero whenever rvalid is low
//   err      address out of range, qualified by rvalid
//
// state | meaning
// IDLE  | ready high, waiting for valid
// WAIT  | request captured, wait-state down-counter running
// RESP  | rvalid high for one cycle; a write commits on the closing edge
module reg_bank_slave #(
  parameter int DW       = 8,
  parameter int NREG     = 4,
  parameter int AW       = 2,
  parameter int WAIT_CYC = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          valid,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
`ifdef REG_BANK_WSTRB_EN
  input  logic [DW/8-1:0] wstrb,
`endif
  output logic          ready,
  output logic          rvalid,
  output logic [DW-1:0] rdata,
  output logic          err
);

  localparam int NB = DW / 8;
  // The counter is loaded with WAIT_CYC-1 so WAIT lasts exactly WAIT_CYC cycles.
  localparam logic [3:0]  CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;
  localparam logic [AW:0] NREG_W   = (AW + 1)'(NREG);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t          state, state_nxt;
  logic [3:0]      cnt, cnt_nxt;
  logic            we_q;
  logic [AW-1:0]   addr_q;
  logic [DW-1:0]   wdata_q;
  logic [NB-1:0]   strb_q;
  logic [DW-1:0]   regs [NREG];
  logic [DW-1:0]   rd_sel;
  logic [DW-1:0]   wr_mask;
  logic            accept;
  logic            in_range;
  logic            commit;

`ifndef REG_BANK_WSTRB_EN
  assign strb_q = '1;
`endif

  assign ready    = (state == IDLE) && !rst;
  assign accept   = valid && ready;
  assign in_range = {1'b0, addr_q} < NREG_W;
  assign commit   = (state == RESP) && we_q && in_range;

  // rvalid is gated by rst so that a reset landing in RESP yields no response.
  assign rvalid = (state == RESP) && !rst;
  assign err    = rvalid && !in_range;
  assign rdata  = (rvalid && !we_q && in_range) ? rd_sel : '0;

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NREG; i++) begin
      if (addr_q == AW'(i)) rd_sel = regs[i];
    end
  end

  always_comb begin
    wr_mask = '0;
    for (int b = 0; b < NB; b++) begin
      wr_mask[8*b +: 8] = {8{strb_q[b]}};
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (WAIT_CYC == 0) begin
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt == 4'd0) state_nxt = RESP;
        else             cnt_nxt   = cnt - 4'd1;
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
`ifdef REG_BANK_WSTRB_EN
      strb_q  <= '0;
`endif
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        we_q    <= we;
        addr_q  <= addr;
        wdata_q <= wdata;
`ifdef REG_BANK_WSTRB_EN
        strb_q  <= wstrb;
`endif
      end
      if (commit) begin
        for (int i = 0; i < NREG; i++) begin
          if (addr_q == AW'(i)) regs[i] <= (regs[i] & ~wr_mask) | (wdata_q & wr_mask);
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_bank_slave.sv
module tb_reg_bank_slave;

  localparam int WC = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // main instance: DW=8, NREG=3, AW=2, WAIT_CYC=1
  logic       valid, we;
  logic [1:0] addr;
  logic [7:0] wdata;
  logic       ready, rvalid, err;
  logic [7:0] rdata;

  // zero-wait instance
  logic       v0, we0;
  logic [1:0] a0;
  logic [7:0] wd0;
  logic       rdy0, rv0, er0;
  logic [7:0] rd0;

`ifdef REG_BANK_WSTRB_EN
  logic        st8 = 1'b1;
  logic        v16, we16;
  logic [1:0]  a16;
  logic [15:0] wd16;
  logic [1:0]  st16;
  logic        rdy16, rv16, er16;
  logic [15:0] rd16;
`endif

  reg_bank_slave #(.DW(8), .NREG(3), .AW(2), .WAIT_CYC(WC)) dut (
    .clk(clk), .rst(rst), .valid(valid), .we(we), .addr(addr), .wdata(wdata),
`ifdef REG_BANK_WSTRB_EN
    .wstrb(st8),
`endif
    .ready(ready), .rvalid(rvalid), .rdata(rdata), .err(err)
  );

  reg_bank_slave #(.DW(8), .NREG(3), .AW(2), .WAIT_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .valid(v0), .we(we0), .addr(a0), .wdata(wd0),
`ifdef REG_BANK_WSTRB_EN
    .wstrb(st8),
`endif
    .ready(rdy0), .rvalid(rv0), .rdata(rd0), .err(er0)
  );

`ifdef REG_BANK_WSTRB_EN
  reg_bank_slave #(.DW(16), .NREG(3), .AW(2), .WAIT_CYC(1)) dut16 (
    .clk(clk), .rst(rst), .valid(v16), .we(we16), .addr(a16), .wdata(wd16),
    .wstrb(st16),
    .ready(rdy16), .rvalid(rv16), .rdata(rd16), .err(er16)
  );
`endif

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic       err;
    logic [7:0] rdata;
    int         cyc;
  } exp_t;
  exp_t sbq[$];
  exp_t mon_e;

  // scoreboard for the main instance
  always @(negedge clk) begin
    if (rvalid === 1'b1) begin
      n_vec++;
      if (sbq.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_rvalid: got rvalid=1 at cycle %0d, required no response", cyc);
      end else begin
        mon_e = sbq.pop_front();
        if (rdata !== mon_e.rdata || err !== mon_e.err || cyc != mon_e.cyc) begin
          n_err++;
          $display("FAIL resp: got rdata=%h err=%b cycle=%0d, required rdata=%h err=%b cycle=%0d",
                   rdata, err, cyc, mon_e.rdata, mon_e.err, mon_e.cyc);
        end
      end
    end else if (rdata !== 8'h00 || err !== 1'b0 || rvalid !== 1'b0) begin
      n_err++;
      $display("FAIL idle_outputs: got rvalid=%b rdata=%h err=%b, required 0/00/0", rvalid, rdata, err);
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (ready !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (ready !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: got ready=%b, required 1", ready);
    end
  endtask

  // Called at a negedge; returns at the negedge of the response cycle.
  task automatic do_req(input logic w, input logic [1:0] a, input logic [7:0] d,
                        input logic e_err, input logic [7:0] e_rd);
    int k;
    wait_ready();
    if (ready !== 1'b1) return;
    valid = 1'b1; we = w; addr = a; wdata = d;
    sbq.push_back('{e_err, e_rd, cyc + 1 + WC});
    @(posedge clk);
    #1;
    // keep valid high with junk while busy: must be ignored
    we = ~w; addr = ~a; wdata = ~d;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rvalid !== 1'b1 && k < 10);
    valid = 1'b0;
    if (rvalid !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL rvalid_timeout: got no rvalid after %0d cycles, required one at %0d", k, WC + 1);
    end
  endtask

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       e_err;
    logic [7:0] e_rd;
  } txn_t;

  typedef struct {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
    logic       e_rdy;
    logic       e_rv;
    logic       e_err;
    logic [7:0] e_rd;
  } cyc_t;

`ifdef REG_BANK_WSTRB_EN
  task automatic xfer16(input logic w, input logic [1:0] a, input logic [15:0] d,
                        input logic [1:0] s, output logic [15:0] r, output logic e);
    int k = 0;
    while (rdy16 !== 1'b1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    v16 = 1'b1; we16 = w; a16 = a; wd16 = d; st16 = s;
    @(posedge clk);
    #1 v16 = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (rv16 !== 1'b1 && k < 10);
    r = rd16;
    e = er16;
    if (rv16 !== 1'b1) begin
      n_vec++;
      n_err++;
      $display("FAIL wstrb_timeout: got no rvalid, required one");
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    txn_t tv[$];
    cyc_t cv[$];
    int   k;
`ifdef REG_BANK_WSTRB_EN
    logic [15:0] r16;
    logic        e16;
`endif

    tv = '{
      '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00},
      '{1'b0, 2'd1, 8'h00, 1'b0, 8'h00},
      '{1'b0, 2'd2, 8'h00, 1'b0, 8'h00},
      '{1'b1, 2'd1, 8'hA5, 1'b0, 8'h00},
      '{1'b0, 2'd1, 8'h00, 1'b0, 8'hA5},
      '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00},
      '{1'b0, 2'd2, 8'h00, 1'b0, 8'h00},
      '{1'b1, 2'd3, 8'h3C, 1'b1, 8'h00},
      '{1'b0, 2'd3, 8'h00, 1'b1, 8'h00},
      '{1'b0, 2'd0, 8'h00, 1'b0, 8'h00},
      '{1'b0, 2'd1, 8'h00, 1'b0, 8'hA5},
      '{1'b0, 2'd2, 8'h00, 1'b0, 8'h00},
      '{1'b1, 2'd2, 8'h77, 1'b0, 8'h00},
      '{1'b0, 2'd2, 8'h00, 1'b0, 8'h77}
    };

    // zero-wait instance, valid held high every cycle
    cv = '{
      '{1'b1, 2'd1, 8'h5A, 1'b1, 1'b0, 1'b0, 8'h00},
      '{1'b0, 2'd1, 8'hEE, 1'b0, 1'b1, 1'b0, 8'h00},
      '{1'b0, 2'd1, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00},
      '{1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0, 8'h5A},
      '{1'b0, 2'd3, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00},
      '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1, 8'h00},
      '{1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00},
      '{1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00}
    };

    valid = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    v0 = 1'b0; we0 = 1'b0; a0 = '0; wd0 = '0;
`ifdef REG_BANK_WSTRB_EN
    v16 = 1'b0; we16 = 1'b0; a16 = '0; wd16 = '0; st16 = '0;
`endif
    rst = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || rdata !== 8'h00 || err !== 1'b0) begin
      n_err++;
      $display("FAIL reset_main: got ready=%b rvalid=%b rdata=%h err=%b, required 0/0/00/0",
               ready, rvalid, rdata, err);
    end
    n_vec++;
    if (rdy0 !== 1'b0 || rv0 !== 1'b0 || rd0 !== 8'h00 || er0 !== 1'b0) begin
      n_err++;
      $display("FAIL reset_zw: got ready=%b rvalid=%b rdata=%h err=%b, required 0/0/00/0",
               rdy0, rv0, rd0, er0);
    end
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    n_vec++;
    if (ready !== 1'b1 || rdy0 !== 1'b1) begin
      n_err++;
      $display("FAIL ready_after_reset: got ready=%b ready_zw=%b, required 1/1", ready, rdy0);
    end

    foreach (tv[i]) do_req(tv[i].we, tv[i].addr, tv[i].wdata, tv[i].e_err, tv[i].e_rd);

    // reset during WAIT aborts a write to addr 2
    wait_ready();
    valid = 1'b1; we = 1'b1; addr = 2'd2; wdata = 8'hFF;
    @(posedge clk);
    #1 valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 2'd2, 8'h00, 1'b0, 8'h00);
    do_req(1'b0, 2'd1, 8'h00, 1'b0, 8'h00);

    // reset landing in RESP: no rvalid, no commit
    wait_ready();
    valid = 1'b1; we = 1'b1; addr = 2'd0; wdata = 8'h11;
    @(posedge clk);
    #1 valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_req(1'b0, 2'd0, 8'h00, 1'b0, 8'h00);

    k = 0;
    while (sbq.size() > 0 && k < 20) begin
      @(negedge clk);
      k++;
    end
    n_vec++;
    if (sbq.size() != 0) begin
      n_err++;
      $display("FAIL missing_resp: got %0d responses outstanding, required 0", sbq.size());
    end

    // zero-wait sequence
    foreach (cv[i]) begin
      @(posedge clk);
      #1;
      v0 = 1'b1; we0 = cv[i].we; a0 = cv[i].addr; wd0 = cv[i].wdata;
      @(negedge clk);
      n_vec++;
      if (rdy0 !== cv[i].e_rdy || rv0 !== cv[i].e_rv || er0 !== cv[i].e_err || rd0 !== cv[i].e_rd) begin
        n_err++;
        $display("FAIL zw_row%0d: got ready=%b rvalid=%b err=%b rdata=%h, required %b/%b/%b/%h",
                 i, rdy0, rv0, er0, rd0, cv[i].e_rdy, cv[i].e_rv, cv[i].e_err, cv[i].e_rd);
      end
    end
    @(posedge clk);
    #1 v0 = 1'b0;
    @(negedge clk);

`ifdef REG_BANK_WSTRB_EN
    xfer16(1'b1, 2'd0, 16'h1234, 2'b11, r16, e16);
    xfer16(1'b1, 2'd0, 16'hABCD, 2'b01, r16, e16);
    xfer16(1'b0, 2'd0, 16'h0000, 2'b00, r16, e16);
    n_vec++;
    if (r16 !== 16'h12CD || e16 !== 1'b0) begin
      n_err++;
      $display("FAIL wstrb_merge: got rdata=%h err=%b, required 12cd/0", r16, e16);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_bank_slave.md
REG_BANK_SLAVE -- requirements
Module: reg_bank_slave

Interface
REQ-001 SHALL have parameter DW, default 8: register and data width in bits, a multiple of 8.
REQ-002 SHALL have parameter NREG, default 4: number of implemented registers, 1..2**AW.
REQ-003 SHALL have parameter AW, default 2: address width in bits.
REQ-004 SHALL have parameter WAIT_CYC, default 1: wait states between accept and response, 0..15.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port valid, input, 1 bit: request present.
REQ-008 SHALL have port we, input, 1 bit: 1 = write, 0 = read.
REQ-009 SHALL have port addr, input, AW bits: register index.
REQ-010 SHALL have port wdata, input, DW bits: write data.
REQ-011 SHALL have port ready, output, 1 bit: slave can accept a request.
REQ-012 SHALL have port rvalid, output, 1 bit: one-cycle response strobe.
REQ-013 SHALL have port rdata, output, DW bits: read data, qualified by rvalid.
REQ-014 SHALL have port err, output, 1 bit: address out of range, qualified by rvalid.

Function
REQ-015 SHALL implement an FSM with states IDLE, WAIT and RESP.
REQ-016 SHALL drive ready=1 only in IDLE with rst low; a request is accepted on a clock edge where valid=1 and ready=1, and we/addr/wdata are captured on that edge.
REQ-017 SHALL transition IDLE->WAIT on accept when WAIT_CYC>0 and IDLE->RESP when WAIT_CYC=0.
REQ-018 SHALL remain in WAIT for exactly WAIT_CYC cycles, counted by a 4-bit down-counter, then enter RESP.
REQ-019 SHALL hold RESP for exactly one cycle with rvalid=1, then return to IDLE; back-to-back requests are therefore separated by at least one non-ready cycle.
REQ-020 SHALL place the rvalid cycle WAIT_CYC+1 cycles after the accepting edge.
REQ-021 SHALL, for a read, drive rdata = reg[captured addr] in the RESP cycle; rdata SHALL be 0 whenever rvalid=0.
REQ-022 SHALL, for a write, update reg[captured addr] on the edge ending RESP and drive rdata=0 in RESP; a read accepted afterwards SHALL return the new value.
REQ-023 SHALL treat a captured addr >= NREG as out of range: err=1 in RESP, no register modified, rdata=0.
REQ-024 SHALL ignore valid in WAIT and RESP; inputs changing there SHALL have no effect.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, set state=IDLE, wait counter=0, all NREG registers=0, rvalid=0, rdata=0 and err=0.
REQ-026 SHALL drive ready=0 while rst=1.
REQ-027 SHALL abort any in-flight access when rst is asserted in WAIT or RESP: no write commits and no rvalid is produced.

Configuration
REQ-028 SHALL support macro REG_BANK_WSTRB_EN; when defined, the block SHALL add input wstrb, DW/8 bits, captured on accept, and a write SHALL update only the bytes whose strobe bit is 1.
REQ-029 SHALL, without REG_BANK_WSTRB_EN, have no wstrb port and every write SHALL update all DW bits.

Verification (DW=8, NREG=3, AW=2, WAIT_CYC=1 unless stated)
REQ-030 Bench SHALL cover: hold rst high 3 cycles then release -> ready=1 on the next cycle; reads of addr 0..2 return 0x00, rvalid each 2 cycles after accept.
REQ-031 Bench SHALL cover: write 0xA5 to addr 1, then read addr 1 -> rdata=0xA5, err=0; addr 0 and addr 2 still read 0x00.
REQ-032 Bench SHALL cover: write 0x3C to addr 3 -> err=1 on the rvalid cycle; a subsequent read of addr 3 returns err=1 and rdata=0, and addrs 0..2 are unchanged.
REQ-033 Bench SHALL cover: accept a write of 0xFF to addr 2, assert rst during WAIT -> no rvalid, and addr 2 reads 0x00 after reset.
REQ-034 Bench SHALL cover: WAIT_CYC=0 with valid held high -> rvalid exactly 1 cycle after each accept, and ready toggling 1,0,1,0.
REQ-035 Bench SHALL cover: with REG_BANK_WSTRB_EN, DW=16, addr 0 preloaded with 0x1234, write 0xABCD with wstrb=2'b01 -> addr 0 reads 0x12CD.
